// File: rtl/ppm_tx_pkg.sv
// Shared constants and types for the PPM transmitter path.
// Holds the byte/symbol widths and the serializer state encoding.
package ppm_tx_pkg;

  localparam int PPM_DATA_W = 8;
  localparam int PPM_SYM_W  = 2;

  typedef enum logic {
    IDLE,
    SEND
  } ppm_state_e;

endpackage

// File: rtl/shift_two.sv
// Byte-to-dibit serializer feeding the PPM slot encoder.
// Define SHIFT_TWO_LSB_FIRST_EN to emit the LSB dibit first.
module shift_two
  import ppm_tx_pkg::*;
#(
  parameter int DATA_W = PPM_DATA_W,
  parameter int SYM_W  = PPM_SYM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe,
  output logic [SYM_W-1:0]  data_out,
  output logic              data_send_done
);

  localparam int NSYM = DATA_W / SYM_W;
  localparam int CW   = (NSYM > 1) ? $clog2(NSYM) : 1;

  localparam logic [CW-1:0] LAST  = CW'(NSYM - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic          DONE1 = (NSYM == 1);

  ppm_state_e        state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CW-1:0]     cnt_q;
  logic [SYM_W-1:0]  sym_q;
  logic              done_q;

  function automatic logic [SYM_W-1:0] head(
    input logic [DATA_W-1:0] x
  );
`ifdef SHIFT_TWO_LSB_FIRST_EN
    head = x[SYM_W-1:0];
`else
    head = x[DATA_W-1 -: SYM_W];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rest(
    input logic [DATA_W-1:0] x
  );
`ifdef SHIFT_TWO_LSB_FIRST_EN
    rest = x >> SYM_W;
`else
    rest = x << SYM_W;
`endif
  endfunction

  // done_q high means the final dibit is on the output now,
  // so this edge may accept the next byte without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (strobe) begin
            sreg_q  <= rest(data_in);
            sym_q   <= head(data_in);
            cnt_q   <= ONE;
            done_q  <= DONE1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (done_q) begin
            done_q <= 1'b0;
            if (strobe) begin
              sreg_q <= rest(data_in);
              sym_q  <= head(data_in);
              cnt_q  <= ONE;
              done_q <= DONE1;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end else begin
            sreg_q <= rest(sreg_q);
            sym_q  <= head(sreg_q);
            done_q <= (cnt_q == LAST);
            cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = sym_q;
  assign data_send_done = done_q;

endmodule

// File: tb/tb_shift_two.sv
// Scoreboard bench for shift_two.
// Honours SHIFT_TWO_LSB_FIRST_EN for expected dibit order.
module tb_shift_two;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       strobe;
  logic [1:0] data_out;
  logic       data_send_done;

  typedef struct {
    logic [1:0] sym;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] last_sym;
  int         n_chk;
  int         n_fail;

  shift_two dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .strobe         (strobe),
    .data_out       (data_out),
    .data_send_done (data_send_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] dibit(
    input logic [7:0] b,
    input int         k
  );
    logic [7:0] v;
    v = b;
`ifdef SHIFT_TWO_LSB_FIRST_EN
    return v[2*k +: 2];
`else
    return v[7-2*k -: 2];
`endif
  endfunction

  // Reference: a byte is taken whenever nothing is queued.
  always @(posedge clk) begin
    if (rst_n && strobe && sb.size() == 0) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.sym  = dibit(data_in, k);
        e.done = (k == 3);
        sb.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_sym = e.sym;
    end else begin
      e.sym  = last_sym;
      e.done = 1'b0;
    end
    chk("data_out", 32'(data_out), 32'(e.sym));
    chk("done", 32'(data_send_done), 32'(e.done));
  end

  task automatic drive(
    input logic       s,
    input logic [7:0] d
  );
    @(negedge clk);
    strobe  = s;
    data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    last_sym = 2'b00;
    rst_n    = 1'b1;
    strobe   = 1'b1;
    data_in  = 8'h6C;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // single byte, one-cycle strobe
    drive(1'b1, 8'h6C);
    idle(8);

    // continuous strobe
    for (int i = 0; i < 12; i++) drive(1'b1, 8'h6C);
    idle(8);

    // back-to-back, mid-byte data ignored
    drive(1'b1, 8'h6C);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'($urandom_range(0, 255)));
    drive(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 8'($urandom_range(0, 255)));
    idle(6);

    // async reset mid-byte
    drive(1'b1, 8'h6C);
    drive(1'b0, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    last_sym = 2'b00;
    #1;
    chk("async_out", 32'(data_out), 32'd0);
    chk("async_done", 32'(data_send_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    drive(1'b1, 8'hA5);
    idle(8);

    chk("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
